// File: rtl/dmem_req_ctrl.sv
// Data-memory request controller: registers one core load/store, handshakes it to memory, returns load data.
// Latency: request reaches memory 1 cycle after req_valid_i; write stalls >=1 cycle, read >=2 cycles.
// Backpressure: stall_o holds the core until memory accepts a write or read data is returned; optional DMEM_TIMEOUT_EN adds a sticky error state.
module dmem_req_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid_i,
    input  logic              req_wen_i,
    input  logic              req_byte_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              mem_valid_o,
    output logic              mem_wen_o,
    output logic              mem_byte_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_yumi_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              mem_yumi_o,
    output logic              err_o
);

    localparam int NLANES = DATA_W / 8;
    localparam int OFF_W  = (NLANES > 1) ? $clog2(NLANES) : 1;

    // Reject parameter sets the byte-lane logic cannot handle.
    if ((DATA_W % 8) != 0 || DATA_W < 16 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("dmem_req_ctrl: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        DMEM_IDLE      = 2'd0,
        DMEM_REQ_SENT  = 2'd1,
        DMEM_REQ_ACKED = 2'd2
`ifdef DMEM_TIMEOUT_EN
        , DMEM_ERR     = 2'd3
`endif
    } dmem_state_e;

    dmem_state_e       state_q, state_d;
    logic              wen_q, wen_d;
    logic              byte_q, byte_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              capture;
    logic              wr_accept;
    logic              in_err;
    logic [7:0]        byte_sel;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Pick the addressed byte lane out of the returned memory word.
    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (addr_q[OFF_W-1:0] == OFF_W'(i)) begin
                byte_sel = mem_rdata_i[8*i +: 8];
            end
        end
    end

    // Next-state, request capture and read-data capture.
    always_comb begin
        state_d       = state_q;
        wen_d         = wen_q;
        byte_d        = byte_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        capture       = 1'b0;
        wr_accept     = 1'b0;

        case (state_q)
            DMEM_IDLE: begin
                // While rdata_valid is high the core is still holding the op that just completed.
                if (req_valid_i && !rdata_valid_q) begin
                    state_d = DMEM_REQ_SENT;
                    wen_d   = req_wen_i;
                    byte_d  = req_byte_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_byte_i ? {NLANES{req_wdata_i[7:0]}} : req_wdata_i;
                end
            end
            DMEM_REQ_SENT: begin
                if (mem_yumi_i) begin
                    if (wen_q) begin
                        state_d   = DMEM_IDLE;
                        wr_accept = 1'b1;
                    end else if (mem_rvalid_i) begin
                        state_d = DMEM_IDLE;
                        capture = 1'b1;
                    end else begin
                        state_d = DMEM_REQ_ACKED;
                    end
                end
            end
            DMEM_REQ_ACKED: begin
                if (mem_rvalid_i) begin
                    state_d = DMEM_IDLE;
                    capture = 1'b1;
                end
            end
`ifdef DMEM_TIMEOUT_EN
            DMEM_ERR: begin
                state_d = DMEM_ERR;
            end
`endif
            default: begin
                state_d = DMEM_IDLE;
            end
        endcase

        if (capture) begin
            rdata_d       = byte_q ? {{(DATA_W-8){1'b0}}, byte_sel} : mem_rdata_i;
            rdata_valid_d = 1'b1;
        end

`ifdef DMEM_TIMEOUT_EN
        // Count cycles of an unfinished transaction; the last allowed cycle diverts to the error state.
        cnt_d = '0;
        if ((state_q == DMEM_REQ_SENT || state_q == DMEM_REQ_ACKED) && state_d != DMEM_IDLE) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                state_d = DMEM_ERR;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= DMEM_IDLE;
            wen_q         <= 1'b0;
            byte_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wen_q         <= wen_d;
            byte_q        <= byte_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    // Timeout counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign in_err = (state_q == DMEM_ERR);
`else
    assign in_err = 1'b0;
`endif

    assign err_o         = in_err;
    assign mem_valid_o   = (state_q == DMEM_REQ_SENT);
    assign mem_wen_o     = wen_q;
    assign mem_byte_o    = byte_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign mem_yumi_o    = capture;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    // Gated by reset_n so that the core sees no stall while the block is held in reset.
    assign stall_o       = reset_n & (in_err | (req_valid_i & ~wr_accept & ~rdata_valid_q));

endmodule

// File: doc/dmem_req_ctrl.md
DMEM_REQ_CTRL -- requirements
Module: dmem_req_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, memory data width in bits; a multiple of 8 and at least 16.
REQ-002 Parameter ADDR_W, default 12, byte address width, equal to data_mem_addr_width_gp.
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum cycles in flight before error; only used when DMEM_TIMEOUT_EN is defined.
REQ-004 The block SHALL have one clock, clk; reset is reset_n, asynchronous and active-low.
REQ-005 Port list, as name / direction / width / meaning:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- req_valid_i  in  1  core holds a memory op until stall_o is low
- req_wen_i  in  1  write = 1, read = 0
- req_byte_i  in  1  byte op (LBU/SB)
- req_addr_i  in  ADDR_W  byte address
- req_wdata_i  in  DATA_W  store data
- stall_o  out  1  core must hold its pipeline
- rdata_o  out  DATA_W  load result
- rdata_valid_o  out  1  one-cycle pulse when rdata_o is valid
- mem_valid_o  out  1  request to memory
- mem_wen_o  out  1  registered copy of req_wen_i
- mem_byte_o  out  1  registered copy of req_byte_i
- mem_addr_o  out  ADDR_W  registered copy of req_addr_i
- mem_wdata_o  out  DATA_W  store data, with the byte replicated on all lanes when byte op
- mem_yumi_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  memory read data valid
- mem_rdata_i  in  DATA_W  memory read data
- mem_yumi_o  out  1  core consumed the read data
- err_o  out  1  sticky timeout error

Function
REQ-006 States SHALL be DMEM_IDLE, DMEM_REQ_SENT, DMEM_REQ_ACKED, plus DMEM_ERR when timeout is enabled.
REQ-007 In IDLE, with req_valid_i=1 and rdata_valid_o=0, the block SHALL register the request fields and go to REQ_SENT on the next edge.
REQ-008 In IDLE, with rdata_valid_o=1, the block SHALL NOT start a request, because the held request is the one completing.
REQ-009 mem_valid_o SHALL equal (state==REQ_SENT), so the earliest request reaches memory one cycle after req_valid_i.
REQ-010 In REQ_SENT, on mem_yumi_i=1 for a write, the block SHALL go to IDLE, with stall_o low in that same cycle.
REQ-011 In REQ_SENT, on mem_yumi_i=1 for a read with mem_rvalid_i=0, the block SHALL go to REQ_ACKED.
REQ-012 In REQ_SENT, on mem_yumi_i=1 and mem_rvalid_i=1 in the same cycle for a read, the block SHALL capture the data and go directly to IDLE.
REQ-013 In REQ_ACKED, on mem_rvalid_i=1, the block SHALL capture the data, go to IDLE and assert mem_yumi_o combinationally in that same cycle.
REQ-014 rdata_valid_o SHALL pulse for exactly one cycle, in the cycle after capture.
REQ-015 rdata_o SHALL be the registered captured data, and SHALL hold its value until the next capture.
REQ-016 For a byte read, rdata_o SHALL be the byte selected by addr[log2(DATA_W/8)-1:0], zero-extended to DATA_W.
REQ-017 stall_o SHALL be asserted whenever req_valid_i=1, except in the write-accept cycle (REQ-010) and in cycles where rdata_valid_o=1.
REQ-018 mem_yumi_i SHALL be ignored outside REQ_SENT, and mem_rvalid_i SHALL be ignored in IDLE.
REQ-019 Minimum latency SHALL be 1 cycle of stall for a write and 2 cycles of stall for a read.

Reset
REQ-020 On reset_n low, the block SHALL go immediately to IDLE, including mid-transaction; the in-flight request is dropped.
REQ-021 During reset, all outputs SHALL be 0, including rdata_o and err_o.

Configuration
REQ-022 With DMEM_TIMEOUT_EN defined, the block SHALL count cycles spent in REQ_SENT or REQ_ACKED, clearing the count on entry to IDLE.
REQ-023 With DMEM_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYC the block SHALL enter DMEM_ERR.
REQ-024 In DMEM_ERR, err_o=1, stall_o=1, mem_valid_o=0 and mem_yumi_o=0, and the state SHALL be left only by reset.
REQ-025 Without DMEM_TIMEOUT_EN, the counter and DMEM_ERR SHALL be absent and err_o SHALL be tied to 0.

Verification
REQ-026 Write to address 0x010 with data 0xDEADBEEF and mem_yumi_i in the first REQ_SENT cycle -> mem_valid_o high for 1 cycle, stall_o high for 1 cycle, mem_wdata_o=0xDEADBEEF.
REQ-027 Read with mem_yumi_i at cycle 1 and mem_rvalid_i at cycle 4 with data 0x12345678 -> mem_yumi_o high at cycle 4, rdata_valid_o high at cycle 5, rdata_o=0x12345678.
REQ-028 Byte read at address 0x003 with mem_rdata_i=0xAABBCCDD, yumi and rvalid in the same cycle -> rdata_o=0x000000AA, with no REQ_ACKED cycle.
REQ-029 Two back-to-back reads with req_valid_i held high -> exactly two mem_valid_o episodes and no duplicate request in the rdata_valid_o cycle.
REQ-030 reset_n pulsed low while in REQ_ACKED -> all outputs 0 immediately; a later mem_rvalid_i produces no rdata_valid_o.
REQ-031 With DMEM_TIMEOUT_EN, TIMEOUT_CYC=8 and mem_yumi_i never asserted -> err_o rises 8 cycles after mem_valid_o rises, and stall_o stays high until reset.
